reflet_int_conditioner: RTL and testbench

Conditions the four raw external interrupt lines before they reach the interrupt controller's ext_int[3:0] input. Per line, it performs:
- metastability synchronisation;
- glitch filtering;
- optional rising-edge capture into a pending latch, cleared by an acknowledge from the core.

Lost-event flags are also exported for status reads. The block sits between the pads/peripherals and the interrupt controller; one instance serves all four lines.

---
 rtl/reflet_int_conditioner.sv | 117 +++++++++++
 tb/tb_reflet_int_conditioner.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/reflet_int_conditioner.sv
// Conditions four raw external interrupt lines: synchronise, glitch-filter and
// optionally latch rising edges until acknowledged, with sticky lost-event flags.
module reflet_int_conditioner #(
    parameter int         sync_stages   = 2,
    parameter int         filter_cycles = 3,
    parameter logic [3:0] edge_mode     = 4'b1111
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] raw_int,
    input  logic [3:0] int_enable,
    input  logic       ack_valid,
    input  logic [1:0] ack_id,
    input  logic [3:0] clear_lost,
    output logic [3:0] ext_int,
    output logic [3:0] pending,
    output logic [3:0] lost
);
    localparam logic [3:0] FILT_LIMIT = 4'(filter_cycles);

    logic [sync_stages-1:0][3:0] sync_r;
    logic [3:0]                  sync_s;
    logic [3:0][3:0]             cnt_r;
    logic [3:0][3:0]             cnt_s;
    logic [3:0]                  filt_r;
    logic [3:0]                  filt_s;
    logic [3:0]                  filt_d_r;
    logic [3:0]                  rise_r;
    logic [3:0]                  out_r;
    logic [3:0]                  out_s;
    logic [3:0]                  lost_r;
    logic [3:0]                  lost_s;
    logic [3:0]                  ack_hit_s;

    assign sync_s = sync_r[sync_stages-1];

    // Metastability chain; only the last stage feeds the filter.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_r <= '0;
        end else begin
            sync_r <= {sync_r[sync_stages-2:0], raw_int};
        end
    end

    // Glitch filter: the level only follows after filter_cycles consecutive disagreements.
    always_comb begin
        cnt_s  = cnt_r;
        filt_s = filt_r;
        for (int i = 0; i < 4; i++) begin
            if (sync_s[i] == filt_r[i]) begin
                cnt_s[i] = 4'd0;
            end else if ((cnt_r[i] + 4'd1) == FILT_LIMIT) begin
                filt_s[i] = ~filt_r[i];
                cnt_s[i]  = 4'd0;
            end else begin
                cnt_s[i] = cnt_r[i] + 4'd1;
            end
        end
    end

    // Next pending/output and lost state; rise_r is the registered edge pulse,
    // which puts the edge path one cycle behind the level path.
    always_comb begin
        out_s     = out_r;
        lost_s    = lost_r;
        ack_hit_s = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            ack_hit_s[i] = ack_valid && (ack_id == 2'(i));
            if (edge_mode[i]) begin
                if (!int_enable[i]) begin
                    out_s[i] = 1'b0;
                end else if (rise_r[i]) begin
                    out_s[i] = 1'b1;
                end else if (ack_hit_s[i]) begin
                    out_s[i] = 1'b0;
                end else begin
                    out_s[i] = out_r[i];
                end
                if (rise_r[i] && out_r[i] && int_enable[i] && !ack_hit_s[i]) begin
                    lost_s[i] = 1'b1;
                end else if (clear_lost[i]) begin
                    lost_s[i] = 1'b0;
                end else begin
                    lost_s[i] = lost_r[i];
                end
            end else begin
                out_s[i]  = filt_r[i] & int_enable[i];
                lost_s[i] = 1'b0;
            end
        end
    end

    // Filter state, edge detector and output latches.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r    <= '0;
            filt_r   <= 4'b0000;
            filt_d_r <= 4'b0000;
            rise_r   <= 4'b0000;
            out_r    <= 4'b0000;
            lost_r   <= 4'b0000;
        end else begin
            cnt_r    <= cnt_s;
            filt_r   <= filt_s;
            filt_d_r <= filt_r;
            rise_r   <= filt_r & ~filt_d_r;
            out_r    <= out_s;
            lost_r   <= lost_s;
        end
    end

    assign ext_int = out_r;
    assign pending = out_r;
    assign lost    = lost_r;

endmodule

// File: tb/tb_reflet_int_conditioner.sv
// Directed bench for reflet_int_conditioner (sync 2, filter 3, line 3 level mode).
module tb_reflet_int_conditioner;
    logic       clk;
    logic       reset;
    logic [3:0] raw_int;
    logic [3:0] int_enable;
    logic       ack_valid;
    logic [1:0] ack_id;
    logic [3:0] clear_lost;
    logic [3:0] ext_int;
    logic [3:0] pending;
    logic [3:0] lost;

    int n_checks = 0;
    int n_fail   = 0;

    reflet_int_conditioner #(
        .sync_stages  (2),
        .filter_cycles(3),
        .edge_mode    (4'b0111)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .raw_int   (raw_int),
        .int_enable(int_enable),
        .ack_valid (ack_valid),
        .ack_id    (ack_id),
        .clear_lost(clear_lost),
        .ext_int   (ext_int),
        .pending   (pending),
        .lost      (lost)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // Advance one edge and settle just after it; inputs change here too.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        reset      = 1'b1;
        raw_int    = 4'b0000;
        int_enable = 4'b1111;
        ack_valid  = 1'b0;
        ack_id     = 2'd0;
        clear_lost = 4'b0000;
        tick(1);
        check("rst_ext", ext_int, 4'b0000);
        check("rst_pend", pending, 4'b0000);
        check("rst_lost", lost, 4'b0000);
        tick(1);
        reset = 1'b0;
        tick(3);

        // 1: edge latch on line 0, then ack
        raw_int = 4'b0001;
        tick(6);
        check("t1_e6", ext_int, 4'b0000);
        tick(1);
        check("t1_e7", ext_int, 4'b0001);
        tick(5);
        check("t1_hold", ext_int, 4'b0001);
        ack_valid = 1'b1;
        ack_id    = 2'd0;
        tick(1);
        ack_valid = 1'b0;
        check("t1_ack_ext", ext_int, 4'b0000);
        check("t1_ack_pend", pending, 4'b0000);
        check("t1_lost", lost, 4'b0000);
        raw_int = 4'b0000;
        tick(8);

        // 2: 2-cycle glitch rejected, 3-cycle pulse accepted
        raw_int = 4'b0010;
        tick(2);
        raw_int = 4'b0000;
        tick(10);
        check("t2_glitch_ext", ext_int, 4'b0000);
        check("t2_glitch_pend", pending, 4'b0000);
        raw_int = 4'b0010;
        tick(3);
        raw_int = 4'b0000;
        tick(3);
        check("t2_e6", ext_int, 4'b0000);
        tick(1);
        check("t2_e7", ext_int, 4'b0010);
        ack_valid = 1'b1;
        ack_id    = 2'd1;
        tick(1);
        ack_valid = 1'b0;
        check("t2_ack", ext_int, 4'b0000);
        tick(6);

        // 3: lost flag on line 2, clear, and edge coincident with ack
        raw_int = 4'b0100;
        tick(7);
        check("t3_pend", pending, 4'b0100);
        raw_int = 4'b0000;
        tick(8);
        raw_int = 4'b0100;
        tick(7);
        check("t3_lost", lost, 4'b0100);
        check("t3_pend2", pending, 4'b0100);
        clear_lost = 4'b0100;
        tick(1);
        clear_lost = 4'b0000;
        check("t3_clr", lost, 4'b0000);
        raw_int = 4'b0000;
        tick(8);
        raw_int = 4'b0100;
        tick(6);
        ack_valid = 1'b1;
        ack_id    = 2'd2;
        tick(1);
        ack_valid = 1'b0;
        check("t3_setwin_pend", pending, 4'b0100);
        check("t3_setwin_lost", lost, 4'b0000);
        ack_valid = 1'b1;
        tick(1);
        ack_valid = 1'b0;
        check("t3_ack", pending, 4'b0000);
        raw_int = 4'b0000;
        tick(8);

        // 4: level pass-through on line 3, ack ignored
        raw_int = 4'b1000;
        tick(5);
        check("t4_e5", ext_int, 4'b0000);
        tick(1);
        check("t4_e6", ext_int, 4'b1000);
        check("t4_pend", pending, 4'b1000);
        tick(1);
        ack_valid = 1'b1;
        ack_id    = 2'd3;
        tick(1);
        ack_valid = 1'b0;
        check("t4_ack", ext_int, 4'b1000);
        tick(2);
        raw_int = 4'b0000;
        tick(5);
        check("t4_e15", ext_int, 4'b1000);
        tick(1);
        check("t4_e16", ext_int, 4'b0000);
        check("t4_lost", lost, 4'b0000);

        // 5: disabled line drops events; disabling clears pending
        int_enable = 4'b1110;
        raw_int    = 4'b0001;
        tick(8);
        check("t5_dis", pending, 4'b0000);
        raw_int = 4'b0000;
        tick(8);
        int_enable = 4'b1111;
        raw_int    = 4'b0001;
        tick(7);
        check("t5_pend", pending, 4'b0001);
        int_enable = 4'b1110;
        tick(1);
        check("t5_clear", pending, 4'b0000);
        int_enable = 4'b1111;
        tick(1);
        check("t5_reen", pending, 4'b0000);
        raw_int = 4'b0000;
        tick(8);

        // 6: reset discards state; line held high through reset fires once
        raw_int = 4'b0110;
        tick(7);
        check("t6_pend", ext_int, 4'b0110);
        raw_int = 4'b0000;
        tick(8);
        raw_int = 4'b0110;
        tick(7);
        check("t6_lost", lost, 4'b0110);
        raw_int = 4'b1111;
        tick(3);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check("t6_rst_ext", ext_int, 4'b0000);
        check("t6_rst_pend", pending, 4'b0000);
        check("t6_rst_lost", lost, 4'b0000);
        tick(6);
        check("t6_e6", ext_int, 4'b1000);
        tick(1);
        check("t6_e7", ext_int, 4'b1111);
        tick(10);
        check("t6_hold", ext_int, 4'b1111);
        check("t6_nolost", lost, 4'b0000);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end
endmodule
